// File: rtl/module_uart_register_bank_pkg.sv
// Shared UART register-bank definitions: word addresses, CTRL bit positions
// and the packed view of the CTRL register.
package pkg_UART;

    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_TXDATA = 1;
    localparam int ADDR_RXDATA = 2;

    localparam int CTRL_SEND_BIT         = 0;
    localparam int CTRL_RX_NOT_EMPTY_BIT = 1;
    localparam int CTRL_RX_FULL_BIT      = 2;
    localparam int CTRL_OVERFLOW_BIT     = 3;
    localparam int CTRL_IRQ_EN_BIT       = 4;

    typedef struct packed {
        logic irq_en;
        logic overflow;
        logic rx_full;
        logic rx_not_empty;
        logic send;
    } ctrl_uart_r;

endpackage

// File: rtl/module_uart_register_bank_rx_fifo.sv
// Receive character FIFO. A pop is ignored when empty; a push is dropped
// when full unless a pop frees the slot in the same cycle.
module module_uart_rx_fifo #(
    parameter int CHAR_W   = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [CHAR_W-1:0]           data_i,
    output logic [CHAR_W-1:0]           data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(RX_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    logic [CHAR_W-1:0] mem_q [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    // Status flags and qualified push/pop strobes.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == (PTR_W+1)'(RX_DEPTH));
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        count_o = count_q;
        data_o  = mem_q[rd_ptr_q];
    end

    // Character storage, cleared on reset so no stale data survives.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally at RX_DEPTH; count tracks net occupancy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/module_uart_register_bank.sv
// Bus-facing UART register bank: CTRL/STATUS, TX data and an RX FIFO,
// with registered read data and pop-on-read of the RX data address.
module module_uart_register_bank
    import pkg_UART::*;
#(
    parameter int DATA_W   = 32,
    parameter int CHAR_W   = 8,
    parameter int RX_DEPTH = 8,
    parameter int ADDR_W   = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        bus_we_i,
    input  logic                        bus_re_i,
    input  logic [ADDR_W-1:0]           bus_addr_i,
    input  logic [DATA_W-1:0]           bus_wdata_i,
    output logic [DATA_W-1:0]           bus_rdata_o,
    output logic [CHAR_W-1:0]           tx_data_o,
    output logic                        send_o,
    input  logic                        send_done_i,
    input  logic                        rx_valid_i,
    input  logic [CHAR_W-1:0]           rx_data_i,
    output logic                        rx_empty_o,
    output logic                        rx_full_o,
    output logic [$clog2(RX_DEPTH):0]   rx_count_o,
    output logic                        irq_o
);

    logic              send_q;
    logic              overflow_q;
    logic              irq_en_q;
    logic [DATA_W-1:0] txdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic [CHAR_W-1:0] fifo_head;

    logic              sel_ctrl;
    logic              sel_txdata;
    logic              sel_rxdata;
    logic              ctrl_we;
    logic              txdata_we;
    logic              rx_pop;
    logic              overflow_evt;
    ctrl_uart_r        ctrl_view;
    logic [DATA_W-1:0] ctrl_word;
    logic [DATA_W-1:0] read_value;

    module_uart_rx_fifo #(
        .CHAR_W   (CHAR_W),
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_valid_i),
        .pop_i   (rx_pop),
        .data_i  (rx_data_i),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (rx_count_o)
    );

    // Address decode, strobes, CTRL view and the pre-write read mux.
    always_comb begin
        sel_ctrl     = (bus_addr_i == ADDR_W'(ADDR_CTRL));
        sel_txdata   = (bus_addr_i == ADDR_W'(ADDR_TXDATA));
        sel_rxdata   = (bus_addr_i == ADDR_W'(ADDR_RXDATA));
        ctrl_we      = bus_we_i & sel_ctrl;
        txdata_we    = bus_we_i & sel_txdata;
        rx_pop       = bus_re_i & sel_rxdata & ~fifo_empty;
        overflow_evt = rx_valid_i & fifo_full & ~rx_pop;

        ctrl_view.send         = send_q;
        ctrl_view.rx_not_empty = ~fifo_empty;
        ctrl_view.rx_full      = fifo_full;
        ctrl_view.overflow     = overflow_q;
        ctrl_view.irq_en       = irq_en_q;

        ctrl_word = '0;
        ctrl_word[CTRL_SEND_BIT]         = ctrl_view.send;
        ctrl_word[CTRL_RX_NOT_EMPTY_BIT] = ctrl_view.rx_not_empty;
        ctrl_word[CTRL_RX_FULL_BIT]      = ctrl_view.rx_full;
        ctrl_word[CTRL_OVERFLOW_BIT]     = ctrl_view.overflow;
        ctrl_word[CTRL_IRQ_EN_BIT]       = ctrl_view.irq_en;

        read_value = '0;
        if (sel_ctrl) begin
            read_value = ctrl_word;
        end else if (sel_txdata) begin
            read_value = txdata_q;
        end else if (sel_rxdata && !fifo_empty) begin
            read_value = DATA_W'(fifo_head);
        end
    end

    // CTRL state: send set beats done, a new overflow beats its clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            send_q     <= 1'b0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            if (ctrl_we && bus_wdata_i[CTRL_SEND_BIT]) begin
                send_q <= 1'b1;
            end else if (send_done_i) begin
                send_q <= 1'b0;
            end
            if (overflow_evt) begin
                overflow_q <= 1'b1;
            end else if (ctrl_we && bus_wdata_i[CTRL_OVERFLOW_BIT]) begin
                overflow_q <= 1'b0;
            end
            if (ctrl_we) begin
                irq_en_q <= bus_wdata_i[CTRL_IRQ_EN_BIT];
            end
        end
    end

    // TX data register, stored at full bus width.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            txdata_q <= '0;
        end else if (txdata_we) begin
            txdata_q <= bus_wdata_i;
        end
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (bus_re_i) begin
            rdata_q <= read_value;
        end
    end

    assign bus_rdata_o = rdata_q;
    assign tx_data_o   = txdata_q[CHAR_W-1:0];
    assign send_o      = send_q;
    assign rx_empty_o  = fifo_empty;
    assign rx_full_o   = fifo_full;
    assign irq_o       = irq_en_q & (~fifo_empty | overflow_q);

endmodule

// File: doc/module_uart_register_bank.md
Name: module_uart_register_bank

Overview:
- Parametrised bus-facing register bank for the UART peripheral. Replaces the fixed two-word UART data register.
- Holds three things: a CTRL/STATUS register, a TX data register, and an RX character FIFO with occupancy flags, an overflow flag and an interrupt.
- Sits between the processor load/store path and the UART TX/RX cores.
- Bus reads are registered; reading the RX data address pops the FIFO.

Parameters:
- DATA_W, 32: bus data width, >= 8.
- CHAR_W, 8: UART character width, <= DATA_W.
- RX_DEPTH, 8: RX FIFO depth in entries; power of two, >= 2.
- ADDR_W, 2: bus word-address width, >= 2.

Ports:
- clk_i, in, 1: single clock.
- rst_i, in, 1: reset; asynchronous, active-low.
- bus_we_i, in, 1: bus write strobe.
- bus_re_i, in, 1: bus read strobe.
- bus_addr_i, in, ADDR_W: word address.
- bus_wdata_i, in, DATA_W: write data.
- bus_rdata_o, out, DATA_W: read data, registered.
- tx_data_o, out, CHAR_W: character to transmit (TXDATA[CHAR_W-1:0]).
- send_o, out, 1: TX request level (CTRL.send).
- send_done_i, in, 1: one-cycle pulse from the TX core when a character is finished.
- rx_valid_i, in, 1: one-cycle pulse from the RX core when a character has been received.
- rx_data_i, in, CHAR_W: received character.
- rx_empty_o, out, 1: FIFO empty.
- rx_full_o, out, 1: FIFO full.
- rx_count_o, out, $clog2(RX_DEPTH)+1: FIFO occupancy.
- irq_o, out, 1: interrupt level.

Behaviour:
- Address map:
  - 0 = CTRL.
  - 1 = TXDATA (read/write; the low CHAR_W bits drive tx_data_o).
  - 2 = RXDATA (read-only, pops the FIFO).
  - Any other address reads 0; writes to it are ignored.
- CTRL bit fields; all other bits read 0:
  - bit0 send: write-1-to-set; writing 0 has no effect.
  - bit1 rx_not_empty: read-only.
  - bit2 rx_full: read-only.
  - bit3 overflow: sticky; write-1-to-clear.
  - bit4 irq_en: read/write.
- Reset (asynchronous assert, synchronous release) clears everything:
  - all registers, FIFO pointers and count, and bus_rdata_o = 0.
  - send_o = 0, irq_o = 0, rx_empty_o = 1, rx_full_o = 0, rx_count_o = 0.
  - Reset mid-transfer discards any FIFO content; no partial state survives.
- Read latency:
  - bus_re_i in cycle N gives bus_rdata_o valid in cycle N+1.
  - bus_rdata_o holds its value until the next read.
- RXDATA read:
  - Non-empty FIFO: returns the head character, zero-extended, and pops in the same cycle (count decrements at N+1).
  - Empty FIFO: returns 0 with no pop and no pointer change.
- Simultaneous bus_re_i and bus_we_i: the write takes effect, and the read returns the pre-write value.
- send:
  - Set by a bus write to CTRL with bit0 = 1; cleared by send_done_i.
  - Set and done in the same cycle: the set wins and send_o stays 1.
  - send_o is a level; the TX core samples tx_data_o while send_o = 1.
- FIFO push: rx_valid_i pushes rx_data_i unless the FIFO is full.
  - Push while full with no pop in the same cycle: the character is dropped and overflow is set the next cycle.
  - Push and pop in the same cycle when full: both succeed, the count is unchanged and overflow is not set.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is suppressed, because the read returns 0 for empty.
- Overflow clear vs. new overflow: a W1C write and a new overflow event in the same cycle leave overflow = 1.
- Pointers: write and read pointers are $clog2(RX_DEPTH) bits and wrap modulo RX_DEPTH.
- Count: count width is one bit wider than the pointers; it ranges 0..RX_DEPTH, with full = (count == RX_DEPTH).
- irq_o = irq_en & (rx_not_empty | overflow). It is combinational from registered state, so it is glitch-free relative to clk_i.
- Character width: TXDATA bits above CHAR_W are stored but ignored by tx_data_o.

Decomposition:
- pkg_UART gains:
  - address constants ADDR_CTRL, ADDR_TXDATA and ADDR_RXDATA;
  - CTRL bit-index constants;
  - a packed ctrl_uart_r struct for the CTRL layout.
- One sub-module: module_uart_rx_fifo, parametrised by CHAR_W and RX_DEPTH.
  - Ports: push, pop, data in/out, empty, full, count.
  - The bank instantiates it once and owns the address decode, CTRL, TXDATA and the read-data register.

Test Plan:
1. Reset check: assert rst_i low asynchronously mid-cycle -> outputs go to reset values immediately (send_o = 0, rx_empty_o = 1, rx_count_o = 0); then read CTRL -> 0x0000_0000.
2. TX path:
   - Write TXDATA = 0x0000_0041, then CTRL = 0x1 -> tx_data_o = 0x41, send_o = 1.
   - Pulse send_done_i -> send_o = 0 the next cycle.
   - send_done_i in the same cycle as a CTRL write of 0x1 -> send_o stays 1.
3. RX fill and drain:
   - Push 0x11..0x18 -> rx_full_o = 1, rx_count_o = 8, CTRL reads 0x6.
   - Eight RXDATA reads -> 0x11..0x18 in order, one cycle after each strobe; then rx_empty_o = 1.
   - A ninth read -> 0.
4. Overflow:
   - With the FIFO full, push 0x99 -> it is dropped, CTRL bit3 = 1, count stays 8.
   - Write CTRL = 0x8 -> bit3 clears.
   - Full FIFO with simultaneous push 0x55 and RXDATA read -> no overflow, count 8, and 0x55 is read last.
5. Interrupt:
   - irq_en = 0 with one character pushed -> irq_o = 0.
   - Write CTRL = 0x10 -> irq_o = 1.
   - Pop the character -> irq_o = 0.
6. Wrap-around and unmapped address:
   - Repeat push 5 / pop 5 cycles three times (pointer wrap at depth 8) -> data stays in order and count stays correct.
   - Read address 3 -> 0; write address 3 -> no state change.
